regfile_p: RTL and testbench
============================

# regfile_p

Parametrised general-purpose register file for the tiny16 datapath. It is the successor to the fixed 8×16 file. It provides two registered read ports (src/dst) and one write port. It has a gated output bus that drives zero instead of high-Z, plus a valid flag. It also has dedicated program-counter increment and stack-pointer push/pop hardware. It sits between the instruction decoder (selects, enables) and the ALU/bus (src, dst, out).

## Interface
Parameters:
- WIDTH, 16, data width of every register and port
- DEPTH, 8, number of registers (power of two, ≥4)
- AW, $clog2(DEPTH), select width (derived; not overridden)
- PC_IDX, 0, register index used as program counter
- SP_IDX, 1, register index used as stack pointer
- SP_RESET, 16'h00FF, stack pointer reset value (truncated/zero-extended to WIDTH)
- PC_STEP, 1, amount added on pc_inc

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- src_sel  in  AW  read-port A / out-bus select
- dst_sel  in  AW  read-port B select and write select
- in_en  in  1  write `in` into gpr[dst_sel]
- in  in  WIDTH  write data
- out_en  in  1  drive gpr[src_sel] on out next cycle
- pc_inc  in  1  gpr[PC_IDX] += PC_STEP
- sp_push  in  1  gpr[SP_IDX] -= 1
- sp_pop  in  1  gpr[SP_IDX] += 1
- src  out  WIDTH  registered gpr[src_sel]
- dst  out  WIDTH  registered gpr[dst_sel]
- out  out  WIDTH  registered bus value; 0 when not enabled
- out_valid  out  1  registered copy of out_en
- pc  out  WIDTH  combinational view of gpr[PC_IDX]
- sp  out  WIDTH  combinational view of gpr[SP_IDX]

## Operation
- Reset, with rst high at the edge:
  - All registers are cleared to 0, except gpr[SP_IDX], which loads SP_RESET.
  - src, dst and out are cleared to 0; out_valid to 0.
  - All other inputs are ignored that cycle, including in_en, pc_inc and sp_*.
- Reads:
  - Each edge, src and dst load the pre-edge contents of the selected registers.
  - There is no write-to-read bypass: a same-cycle write appears on the following read.
- Out bus:
  - out ← out_en ? gpr[src_sel] : 0.
  - out_valid ← out_en.
  - The block never drives high-Z.
- Register update priority, per edge, evaluated independently per register:
  1. in_en with dst_sel == r writes `in`. The write overrides any pc_inc or sp op on the same register that cycle.
  2. Otherwise, for r == PC_IDX, pc_inc adds PC_STEP.
  3. Otherwise, for r == SP_IDX:
     - push alone decrements by 1;
     - pop alone increments by 1;
     - push and pop together leave SP unchanged.
- If PC_IDX == SP_IDX, pc_inc takes precedence over sp ops. This configuration is legal but discouraged.
- Arithmetic is modulo 2^WIDTH.
  - PC wraps from all-ones to PC_STEP−1.
  - SP wraps 0 → all-ones on push, and all-ones → 0 on pop.
  - There are no overflow flags.
- A write to a non-special register never disturbs PC or SP updates in the same cycle.
- Out-of-range selects cannot occur, because DEPTH is a power of two.

## Timing
- Read latency is 1 cycle: sel presented before edge N yields src/dst/out after edge N.
- Write latency is 1 cycle: data written at edge N is visible on pc/sp immediately after edge N, and on src/dst after edge N+1.
- pc and sp are combinational from register state only. There is no combinational path from any input to any output.
- If reset is asserted mid-operation, it wins unconditionally at that edge; pending increments and writes are lost.

## Test plan
- **Reset values.** Hold rst 2 cycles with in_en=1 and pc_inc=1 → all gpr 0 except sp=16'h00FF; src=dst=out=0; out_valid=0; pc=0.
- **Write then read.** Write gpr[3]=16'hBEEF, then in the next cycle src_sel=3 with out_en=1. After that edge, src=out=16'hBEEF and out_valid=1. With out_en=0 on the following cycle, out=0 and out_valid=0.
- **No bypass.** With gpr[2]=16'h1111, write gpr[2]=16'h2222 while src_sel=2 in the same cycle → src=16'h1111; one cycle later src=16'h2222.
- **PC behaviour.**
  - 5 consecutive pc_inc → pc=5.
  - Then in_en with dst_sel=PC_IDX, in=16'h0100, together with pc_inc → pc=16'h0100, not 16'h0101.
  - From pc=16'hFFFF, one pc_inc → pc=0.
- **SP behaviour.**
  - From reset, push ×3 → sp=16'h00FC.
  - push+pop together → sp unchanged at 16'h00FC.
  - pop ×4 → sp=16'h0100.
  - With sp=0, one push → sp=16'hFFFF.
- **Parametrised build.** WIDTH=32, DEPTH=16, PC_STEP=4: write gpr[15]=32'hDEADBEEF and read it back on dst; 3 pc_inc → pc=12; sp resets to 32'h000000FF.

Source files
------------

// File: rtl/regfile_p.sv
// regfile_p: parametrised tiny16 register file with two registered read ports,
// one write port, a zero-gated registered output bus, and dedicated PC / SP
// increment hardware. Synchronous active-high reset.
module regfile_p #(
    parameter int unsigned     WIDTH    = 16,
    parameter int unsigned     DEPTH    = 8,
    parameter int unsigned     AW       = $clog2(DEPTH),
    parameter int unsigned     PC_IDX   = 0,
    parameter int unsigned     SP_IDX   = 1,
    parameter logic [WIDTH-1:0] SP_RESET = 'h00FF,
    parameter int unsigned     PC_STEP  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AW-1:0]    src_sel,
    input  logic [AW-1:0]    dst_sel,
    input  logic             in_en,
    input  logic [WIDTH-1:0] in,
    input  logic             out_en,
    input  logic             pc_inc,
    input  logic             sp_push,
    input  logic             sp_pop,
    output logic [WIDTH-1:0] src,
    output logic [WIDTH-1:0] dst,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] sp
);

    localparam logic [AW-1:0]    PcSel  = AW'(PC_IDX);
    localparam logic [AW-1:0]    SpSel  = AW'(SP_IDX);
    localparam logic [WIDTH-1:0] PcStep = WIDTH'(PC_STEP);
    localparam logic [WIDTH-1:0] One    = WIDTH'(1);

    logic [WIDTH-1:0] gpr_q [DEPTH];
    logic [WIDTH-1:0] gpr_d [DEPTH];
    logic [WIDTH-1:0] src_q, dst_q, out_q, out_d;
    logic             out_valid_q;

    // Per-register next state: write beats pc_inc, pc_inc beats SP ops.
    // Push and pop together cancel, so only their XOR moves SP.
    always_comb begin
        for (int unsigned r = 0; r < DEPTH; r++) begin
            gpr_d[r] = gpr_q[r];
            if (in_en && (dst_sel == AW'(r))) begin
                gpr_d[r] = in;
            end else if ((r == PC_IDX) && pc_inc) begin
                gpr_d[r] = gpr_q[r] + PcStep;
            end else if ((r == SP_IDX) && (sp_push ^ sp_pop)) begin
                gpr_d[r] = sp_push ? (gpr_q[r] - One) : (gpr_q[r] + One);
            end
        end
    end

    // Output bus drives zero rather than floating when not enabled.
    always_comb begin
        out_d = out_en ? gpr_q[src_sel] : '0;
    end

    // Register state and registered read ports; reads see pre-edge contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned r = 0; r < DEPTH; r++) begin
                gpr_q[r] <= (r == SP_IDX) ? SP_RESET : '0;
            end
            src_q       <= '0;
            dst_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            for (int unsigned r = 0; r < DEPTH; r++) begin
                gpr_q[r] <= gpr_d[r];
            end
            src_q       <= gpr_q[src_sel];
            dst_q       <= gpr_q[dst_sel];
            out_q       <= out_d;
            out_valid_q <= out_en;
        end
    end

    assign src       = src_q;
    assign dst       = dst_q;
    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign pc        = gpr_q[PcSel];
    assign sp        = gpr_q[SpSel];

endmodule

// File: tb/tb_regfile_p.sv
// Self-checking bench for regfile_p: scoreboard of expected read-port results
// plus directed checks of PC/SP behaviour, and a 32-bit parametrised build.
module tb_regfile_p;

    typedef struct {
        logic [15:0] src;
        logic [15:0] dst;
        logic [15:0] out;
        logic        vld;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, in_en, out_en, pc_inc, sp_push, sp_pop;
    logic [2:0]  src_sel, dst_sel;
    logic [15:0] in_d;
    logic [15:0] src, dst, out, pc, sp;
    logic        out_valid;

    logic        rst32, in_en32, pc_inc32;
    logic [3:0]  dst_sel32;
    logic [31:0] in32, src32, dst32, out32, pc32, sp32;
    logic        out_valid32;

    int checks = 0;
    int errors = 0;

    logic [15:0] m [8];
    exp_t        sb [$];

    always #5 clk = ~clk;

    regfile_p u_dut (
        .clk       (clk),
        .rst       (rst),
        .src_sel   (src_sel),
        .dst_sel   (dst_sel),
        .in_en     (in_en),
        .in        (in_d),
        .out_en    (out_en),
        .pc_inc    (pc_inc),
        .sp_push   (sp_push),
        .sp_pop    (sp_pop),
        .src       (src),
        .dst       (dst),
        .out       (out),
        .out_valid (out_valid),
        .pc        (pc),
        .sp        (sp)
    );

    regfile_p #(
        .WIDTH    (32),
        .DEPTH    (16),
        .SP_RESET (32'h000000FF),
        .PC_STEP  (4)
    ) u_dut32 (
        .clk       (clk),
        .rst       (rst32),
        .src_sel   (4'd0),
        .dst_sel   (dst_sel32),
        .in_en     (in_en32),
        .in        (in32),
        .out_en    (1'b0),
        .pc_inc    (pc_inc32),
        .sp_push   (1'b0),
        .sp_pop    (1'b0),
        .src       (src32),
        .dst       (dst32),
        .out       (out32),
        .out_valid (out_valid32),
        .pc        (pc32),
        .sp        (sp32)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs, push expected read results, advance the model,
    // then compare DUT outputs after the edge.
    task automatic step(input logic r, input logic ie, input logic [2:0] ss,
                        input logic [2:0] ds, input logic [15:0] d, input logic oe,
                        input logic pi, input logic pu, input logic po);
        exp_t        e;
        logic [15:0] nm [8];
        rst = r; in_en = ie; src_sel = ss; dst_sel = ds; in_d = d;
        out_en = oe; pc_inc = pi; sp_push = pu; sp_pop = po;
        if (r) begin
            e = '{16'h0, 16'h0, 16'h0, 1'b0};
            for (int i = 0; i < 8; i++) nm[i] = (i == 1) ? 16'h00FF : 16'h0;
        end else begin
            e = '{m[ss], m[ds], oe ? m[ss] : 16'h0, oe};
            for (int i = 0; i < 8; i++) begin
                nm[i] = m[i];
                if (ie && ds == 3'(i))            nm[i] = d;
                else if (i == 0 && pi)            nm[i] = m[i] + 16'd1;
                else if (i == 1 && pu && !po)     nm[i] = m[i] - 16'd1;
                else if (i == 1 && po && !pu)     nm[i] = m[i] + 16'd1;
            end
        end
        sb.push_back(e);
        for (int i = 0; i < 8; i++) m[i] = nm[i];
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk("src", {16'h0, src}, {16'h0, e.src});
            chk("dst", {16'h0, dst}, {16'h0, e.dst});
            chk("out", {16'h0, out}, {16'h0, e.out});
            chk("out_valid", {31'h0, out_valid}, {31'h0, e.vld});
        end
        chk("pc_model", {16'h0, pc}, {16'h0, m[0]});
        chk("sp_model", {16'h0, sp}, {16'h0, m[1]});
    endtask

    task automatic idle(input logic pi, input logic pu, input logic po);
        step(1'b0, 1'b0, 3'd0, 3'd0, 16'h0, 1'b0, pi, pu, po);
    endtask

    task automatic wr(input logic [2:0] ds, input logic [15:0] d);
        step(1'b0, 1'b1, 3'd0, ds, d, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; in_en = 1'b0; out_en = 1'b0; pc_inc = 1'b0;
        sp_push = 1'b0; sp_pop = 1'b0; src_sel = '0; dst_sel = '0; in_d = '0;
        rst32 = 1'b1; in_en32 = 1'b0; pc_inc32 = 1'b0; dst_sel32 = '0; in32 = '0;
        for (int i = 0; i < 8; i++) m[i] = 16'h0;

        // Reset held two cycles with write and pc_inc asserted
        step(1'b1, 1'b1, 3'd0, 3'd0, 16'h1234, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 3'd0, 3'd0, 16'h1234, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("reset_pc", {16'h0, pc}, 32'h0);
        chk("reset_sp", {16'h0, sp}, 32'h00FF);
        chk("reset_out", {16'h0, out}, 32'h0);

        // Write then read on src and out bus
        wr(3'd3, 16'hBEEF);
        step(1'b0, 1'b0, 3'd3, 3'd0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("rd_src", {16'h0, src}, 32'hBEEF);
        chk("rd_out", {16'h0, out}, 32'hBEEF);
        chk("rd_vld", {31'h0, out_valid}, 32'h1);
        step(1'b0, 1'b0, 3'd3, 3'd0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("gate_out", {16'h0, out}, 32'h0);
        chk("gate_vld", {31'h0, out_valid}, 32'h0);

        // No write-to-read bypass
        wr(3'd2, 16'h1111);
        step(1'b0, 1'b1, 3'd2, 3'd2, 16'h2222, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("nobyp_old", {16'h0, src}, 32'h1111);
        step(1'b0, 1'b0, 3'd2, 3'd0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("nobyp_new", {16'h0, src}, 32'h2222);

        // PC: increments, write priority, wrap
        for (int i = 0; i < 5; i++) idle(1'b1, 1'b0, 1'b0);
        chk("pc_5", {16'h0, pc}, 32'h5);
        step(1'b0, 1'b1, 3'd0, 3'd0, 16'h0100, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("pc_wr_prio", {16'h0, pc}, 32'h0100);
        wr(3'd0, 16'hFFFF);
        idle(1'b1, 1'b0, 1'b0);
        chk("pc_wrap", {16'h0, pc}, 32'h0);

        // SP: push/pop, cancel, wrap both ways
        for (int i = 0; i < 3; i++) idle(1'b0, 1'b1, 1'b0);
        chk("sp_push3", {16'h0, sp}, 32'h00FC);
        idle(1'b0, 1'b1, 1'b1);
        chk("sp_cancel", {16'h0, sp}, 32'h00FC);
        for (int i = 0; i < 4; i++) idle(1'b0, 1'b0, 1'b1);
        chk("sp_pop4", {16'h0, sp}, 32'h0100);
        wr(3'd1, 16'h0000);
        idle(1'b0, 1'b1, 1'b0);
        chk("sp_wrap_dn", {16'h0, sp}, 32'hFFFF);
        idle(1'b0, 1'b0, 1'b1);
        chk("sp_wrap_up", {16'h0, sp}, 32'h0);

        // Write to a plain register alongside PC and SP updates
        step(1'b0, 1'b1, 3'd0, 3'd5, 16'hA5A5, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("side_pc", {16'h0, pc}, 32'h1);
        chk("side_sp", {16'h0, sp}, 32'hFFFF);
        step(1'b0, 1'b0, 3'd5, 3'd5, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("side_r5", {16'h0, dst}, 32'hA5A5);

        // Mid-operation reset wins over everything
        step(1'b1, 1'b1, 3'd5, 3'd1, 16'h7777, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("mid_rst_pc", {16'h0, pc}, 32'h0);
        chk("mid_rst_sp", {16'h0, sp}, 32'h00FF);

        // Random traffic against the model
        for (int i = 0; i < 60; i++) begin
            step(($urandom_range(31) == 0), 1'($urandom), 3'($urandom), 3'($urandom),
                 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        end
        rst = 1'b0; in_en = 1'b0; out_en = 1'b0; pc_inc = 1'b0;
        sp_push = 1'b0; sp_pop = 1'b0;

        // 32-bit, 16-deep build with PC_STEP of 4
        @(posedge clk);
        #1;
        chk("p32_sp_rst", sp32, 32'h000000FF);
        chk("p32_pc_rst", pc32, 32'h0);
        rst32 = 1'b0; in_en32 = 1'b1; dst_sel32 = 4'd15; in32 = 32'hDEADBEEF;
        @(posedge clk);
        #1;
        in_en32 = 1'b0;
        @(posedge clk);
        #1;
        chk("p32_dst", dst32, 32'hDEADBEEF);
        pc_inc32 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
        end
        pc_inc32 = 1'b0;
        chk("p32_pc12", pc32, 32'd12);
        chk("p32_sp_hold", sp32, 32'h000000FF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
